tsn_rx_seq_checker: RTL and testbench
=====================================

TSN_RX_SEQ_CHECKER -- requirements
Module: tsn_rx_seq_checker

Interface
REQ-001 Parameter ETHERTYPE, default 16'h88B5, EtherType that marks a test frame.
REQ-002 Parameter CNT_W, default 32, width of every statistics counter (range 8..32).
REQ-003 rx_fifo_clock  in  1  single clock for all logic.
REQ-004 rx_fifo_resetn  in  1  asynchronous, active-low reset.
REQ-005 rx_axis_fifo_tdata  in  8  received frame byte, destination MAC first.
REQ-006 rx_axis_fifo_tvalid  in  1  byte valid.
REQ-007 rx_axis_fifo_tlast  in  1  last byte of frame.
REQ-008 rx_axis_fifo_tready  out  1  sink ready.
REQ-009 enable  in  1  count and check when 1; when 0 frames are consumed and ignored.
REQ-010 clear  in  1  synchronous clear of counters and sequence tracking.
REQ-011 frame_cnt  out  CNT_W  all frames seen (tlast beats).
REQ-012 match_cnt  out  CNT_W  test frames with a complete sequence field.
REQ-013 runt_cnt  out  CNT_W  test frames ending before sequence field complete.
REQ-014 lost_cnt  out  CNT_W  sum of sequence gaps.
REQ-015 ooo_cnt  out  CNT_W  late, duplicate or out-of-order test frames.
REQ-016 last_seq  out  32  sequence number of most recent matched frame.
REQ-017 seq_valid  out  1  one-cycle pulse when a matched frame is accounted.

Function
REQ-018 Beat = rx_axis_fifo_tvalid & rx_axis_fifo_tready; only beats advance state.
REQ-019 rx_axis_fifo_tready SHALL be 0 in reset and 1 every cycle thereafter.
REQ-020 Byte index counter starts at 0 per frame, increments per beat, saturates at 18, returns to 0 after a tlast beat.
REQ-021 FSM states: HDR (bytes 0-13), SEQ (bytes 14-17), PAYLOAD, SKIP.
REQ-022 HDR: bytes 12-13 compared to ETHERTYPE big-endian; mismatch at byte 12 or 13 -> SKIP; match after byte 13 -> SEQ.
REQ-023 SEQ: bytes 14-17 shift into a 32-bit big-endian sequence register; after byte 17 -> PAYLOAD.
REQ-024 tlast beat in any state returns to HDR with index 0.
REQ-025 Frame accounting occurs the cycle after the tlast beat (latency 1); counters, last_seq and seq_valid update together.
REQ-026 frame_cnt increments on every tlast beat when enable=1.
REQ-027 tlast in HDR with ETHERTYPE matched-so-far at byte 13 or in SEQ (frame under 18 bytes, EtherType matched) -> runt_cnt+1 only.
REQ-028 tlast in PAYLOAD, or tlast on byte 17 -> matched frame: match_cnt+1, last_seq=seq, seq_valid=1.
REQ-029 First matched frame after reset or clear: expected=seq+1, no gap/ooo accounting.
REQ-030 d = seq - expected modulo 2^32; d==0 -> expected=seq+1.
REQ-031 0<d<2^31 -> lost_cnt += d, expected=seq+1.
REQ-032 d>=2^31 (late/duplicate) -> ooo_cnt+1, expected unchanged.
REQ-033 expected wraps 32'hFFFFFFFF+1 -> 0 with no loss counted.
REQ-034 All counters saturate at all-ones; lost_cnt addition saturates, never wraps.
REQ-035 enable sampled on the tlast beat; enable=0 frames change no output and no tracking.
REQ-036 clear=1 zeroes counters, last_seq, seq_valid and first-frame flag next cycle; clear coinciding with accounting wins, that frame is discarded; parser FSM not affected by clear.

Reset
REQ-037 Asynchronous assertion zeroes all counters, last_seq, seq_valid, expected, first-frame flag, byte index, tready; FSM=HDR.
REQ-038 Reset asserted mid-frame discards the partial frame; after release, remaining bytes up to tlast are parsed as a new frame (valid header check required).

Verification
REQ-039 Frames seq 0,1,2 (64 B, ETHERTYPE) -> match_cnt=3, lost_cnt=0, ooo_cnt=0, last_seq=2, three seq_valid pulses.
REQ-040 Seq 5 then 9 -> lost_cnt=3, expected=10; then seq 7 -> ooo_cnt=1, expected stays 10.
REQ-041 Seq 32'hFFFFFFFE, 32'hFFFFFFFF, 0 -> lost_cnt=0, ooo_cnt=0, last_seq=0.
REQ-042 16-byte test frame and one 64-byte EtherType 0x0800 frame -> runt_cnt=1, frame_cnt=2, match_cnt=0.
REQ-043 clear asserted on accounting cycle of seq 3 -> all counters 0 next cycle; following seq 10 treated as first frame, lost_cnt=0.
REQ-044 CNT_W=8, 300 frames with gap 1 each -> frame_cnt, match_cnt and lost_cnt all hold 255; tvalid gaps mid-frame give identical results.

Source files
------------

// File: rtl/tsn_rx_seq_checker_if.sv
// AXI-Stream byte bus feeding the TSN receive sequence checker.
// master drives bytes, slave returns ready.
interface tsn_rx_seq_checker_if;
  logic [7:0] rx_axis_fifo_tdata;
  logic       rx_axis_fifo_tvalid;
  logic       rx_axis_fifo_tlast;
  logic       rx_axis_fifo_tready;

  modport master (
    output rx_axis_fifo_tdata,
    output rx_axis_fifo_tvalid,
    output rx_axis_fifo_tlast,
    input  rx_axis_fifo_tready
  );

  modport slave (
    input  rx_axis_fifo_tdata,
    input  rx_axis_fifo_tvalid,
    input  rx_axis_fifo_tlast,
    output rx_axis_fifo_tready
  );
endinterface

// File: rtl/tsn_rx_seq_checker.sv
// Parses received frames for a test EtherType and tracks a 32-bit
// sequence field, counting matches, runts, lost and out-of-order frames.
module tsn_rx_seq_checker #(
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          CNT_W     = 32
) (
  input  logic                 rx_fifo_clock,
  input  logic                 rx_fifo_resetn,
  tsn_rx_seq_checker_if.slave  rx_axis,
  input  logic                 enable,
  input  logic                 clear,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [CNT_W-1:0]     match_cnt,
  output logic [CNT_W-1:0]     runt_cnt,
  output logic [CNT_W-1:0]     lost_cnt,
  output logic [CNT_W-1:0]     ooo_cnt,
  output logic [31:0]          last_seq,
  output logic                 seq_valid
);

  typedef enum logic [1:0] {
    HDR,
    SEQ,
    PAYLOAD,
    SKIP
  } state_t;

  localparam logic [32:0] CNT_MAX = 33'({CNT_W{1'b1}});

  state_t      state;
  logic [4:0]  idx;
  logic [31:0] seq_sr;
  logic        tready_q;

  logic        acc_vld;
  logic        acc_match;
  logic        acc_runt;
  logic [31:0] acc_seq;

  logic [31:0] expected;
  logic        have_exp;

  logic        beat;
  logic        last_beat;
  logic        et_hi_ok;
  logic        et_lo_ok;
  logic [31:0] seq_nxt;
  logic        last_match;
  logic        last_runt;
  logic [31:0] d;
  logic [32:0] lost_sum;
  logic [CNT_W-1:0] lost_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign rx_axis.rx_axis_fifo_tready = tready_q;

  assign beat      = rx_axis.rx_axis_fifo_tvalid & tready_q;
  assign last_beat = beat & rx_axis.rx_axis_fifo_tlast;
  assign et_hi_ok  = rx_axis.rx_axis_fifo_tdata == ETHERTYPE[15:8];
  assign et_lo_ok  = rx_axis.rx_axis_fifo_tdata == ETHERTYPE[7:0];
  assign seq_nxt   = {seq_sr[23:0], rx_axis.rx_axis_fifo_tdata};

  // Classification of the frame if the current byte is its last.
  assign last_match = (state == PAYLOAD) ||
                      (state == SEQ && idx == 5'd17);
  assign last_runt  = (state == SEQ && idx != 5'd17) ||
                      (state == HDR && idx == 5'd13 && et_lo_ok);

  assign d        = acc_seq - expected;
  assign lost_sum = 33'(lost_cnt) + {1'b0, d};
  assign lost_nxt = (lost_sum > CNT_MAX) ? '1 : lost_sum[CNT_W-1:0];

  always_ff @(posedge rx_fifo_clock or negedge rx_fifo_resetn) begin
    if (!rx_fifo_resetn) begin
      state     <= HDR;
      idx       <= '0;
      seq_sr    <= '0;
      tready_q  <= 1'b0;
      acc_vld   <= 1'b0;
      acc_match <= 1'b0;
      acc_runt  <= 1'b0;
      acc_seq   <= '0;
    end else begin
      tready_q  <= 1'b1;
      acc_vld   <= last_beat & enable;
      acc_match <= last_match;
      acc_runt  <= last_runt;
      acc_seq   <= (state == PAYLOAD) ? seq_sr : seq_nxt;
      if (last_beat) begin
        state <= HDR;
        idx   <= '0;
      end else if (beat) begin
        if (idx != 5'd18) idx <= idx + 5'd1;
        unique case (state)
          HDR: begin
            if (idx == 5'd12 && !et_hi_ok) state <= SKIP;
            else if (idx == 5'd13) state <= et_lo_ok ? SEQ : SKIP;
          end
          SEQ: begin
            seq_sr <= seq_nxt;
            if (idx == 5'd17) state <= PAYLOAD;
          end
          PAYLOAD: ;
          SKIP: ;
        endcase
      end
    end
  end

  // Clear beats a coincident accounting event; that frame is dropped.
  always_ff @(posedge rx_fifo_clock or negedge rx_fifo_resetn) begin
    if (!rx_fifo_resetn) begin
      frame_cnt <= '0;
      match_cnt <= '0;
      runt_cnt  <= '0;
      lost_cnt  <= '0;
      ooo_cnt   <= '0;
      last_seq  <= '0;
      seq_valid <= 1'b0;
      expected  <= '0;
      have_exp  <= 1'b0;
    end else begin
      seq_valid <= 1'b0;
      if (clear) begin
        frame_cnt <= '0;
        match_cnt <= '0;
        runt_cnt  <= '0;
        lost_cnt  <= '0;
        ooo_cnt   <= '0;
        last_seq  <= '0;
        expected  <= '0;
        have_exp  <= 1'b0;
      end else if (acc_vld) begin
        frame_cnt <= sat_inc(frame_cnt);
        if (acc_runt) runt_cnt <= sat_inc(runt_cnt);
        if (acc_match) begin
          match_cnt <= sat_inc(match_cnt);
          last_seq  <= acc_seq;
          seq_valid <= 1'b1;
          if (!have_exp) begin
            have_exp <= 1'b1;
            expected <= acc_seq + 32'd1;
          end else if (d == 32'd0) begin
            expected <= acc_seq + 32'd1;
          end else if (!d[31]) begin
            lost_cnt <= lost_nxt;
            expected <= acc_seq + 32'd1;
          end else begin
            ooo_cnt <= sat_inc(ooo_cnt);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tsn_rx_seq_checker.sv
// Scoreboard bench for tsn_rx_seq_checker (CNT_W=8 to reach saturation).
module tb_tsn_rx_seq_checker;
  localparam int          CNT_W = 8;
  localparam logic [15:0] ET    = 16'h88B5;
  localparam logic [CNT_W-1:0] MAXC = '1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic [CNT_W-1:0] frame_cnt, match_cnt, runt_cnt, lost_cnt, ooo_cnt;
  logic [31:0] last_seq;
  logic seq_valid;

  tsn_rx_seq_checker_if bus ();

  tsn_rx_seq_checker #(.ETHERTYPE(ET), .CNT_W(CNT_W)) dut (
    .rx_fifo_clock  (clk),
    .rx_fifo_resetn (rst_n),
    .rx_axis        (bus),
    .enable         (enable),
    .clear          (clear),
    .frame_cnt      (frame_cnt),
    .match_cnt      (match_cnt),
    .runt_cnt       (runt_cnt),
    .lost_cnt       (lost_cnt),
    .ooo_cnt        (ooo_cnt),
    .last_seq       (last_seq),
    .seq_valid      (seq_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0] f;
    logic [CNT_W-1:0] m;
    logic [CNT_W-1:0] r;
    logic [CNT_W-1:0] l;
    logic [CNT_W-1:0] o;
    logic [31:0]      ls;
    logic             sv;
  } snap_t;

  snap_t sbq[$];
  int total = 0;
  int bad = 0;

  logic [CNT_W-1:0] m_f, m_m, m_r, m_l, m_o;
  logic [31:0] m_ls, m_exp;
  bit m_have;

  logic [1:0] pipe;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) pipe <= 2'b00;
    else pipe <= {pipe[0], bus.rx_axis_fifo_tvalid &
                  bus.rx_axis_fifo_tready & bus.rx_axis_fifo_tlast};

  always @(negedge clk) begin
    if (rst_n) begin
      if (pipe[1]) begin
        snap_t e, g;
        g.f = frame_cnt; g.m = match_cnt; g.r = runt_cnt;
        g.l = lost_cnt; g.o = ooo_cnt; g.ls = last_seq; g.sv = seq_valid;
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL sb_empty: frame accounted, got f=%0d but no expectation queued", g.f);
        end else begin
          e = sbq.pop_front();
          if (g !== e) begin
            bad++;
            $display("FAIL sb_frame: got f=%0d m=%0d r=%0d l=%0d o=%0d ls=%h sv=%b want f=%0d m=%0d r=%0d l=%0d o=%0d ls=%h sv=%b",
                     g.f, g.m, g.r, g.l, g.o, g.ls, g.sv,
                     e.f, e.m, e.r, e.l, e.o, e.ls, e.sv);
          end
        end
      end else begin
        total++;
        if (seq_valid !== 1'b0) begin
          bad++;
          $display("FAIL seq_valid_idle: got %b want 0", seq_valid);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    m_f = '0; m_m = '0; m_r = '0; m_l = '0; m_o = '0;
    m_ls = '0; m_exp = '0; m_have = 1'b0;
  endtask

  task automatic model_acc(input bit is_match, input bit is_runt,
                           input logic [31:0] s, input bit en, input bit clr);
    snap_t e;
    logic [31:0] dd;
    longint tmp;
    bit sv = 1'b0;
    if (clr) begin
      model_clear();
    end else if (en) begin
      m_f = (m_f == MAXC) ? m_f : m_f + 1'b1;
      if (is_runt) m_r = (m_r == MAXC) ? m_r : m_r + 1'b1;
      if (is_match) begin
        m_m = (m_m == MAXC) ? m_m : m_m + 1'b1;
        m_ls = s;
        sv = 1'b1;
        if (!m_have) begin
          m_have = 1'b1;
          m_exp = s + 32'd1;
        end else begin
          dd = s - m_exp;
          if (dd == 32'd0) begin
            m_exp = s + 32'd1;
          end else if (dd < 32'h8000_0000) begin
            tmp = longint'(m_l) + longint'(dd);
            m_l = (tmp > longint'(MAXC)) ? MAXC : CNT_W'(tmp);
            m_exp = s + 32'd1;
          end else begin
            m_o = (m_o == MAXC) ? m_o : m_o + 1'b1;
          end
        end
      end
    end
    e.f = m_f; e.m = m_m; e.r = m_r; e.l = m_l; e.o = m_o;
    e.ls = m_ls; e.sv = sv;
    sbq.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l, input int gap);
    bit ok = 1'b0;
    for (int k = 0; k < 3; k++)
      if (gap > 0 && $urandom_range(99) < gap) begin
        bus.rx_axis_fifo_tvalid = 1'b0;
        @(posedge clk); #1;
      end
    bus.rx_axis_fifo_tdata  = b;
    bus.rx_axis_fifo_tlast  = l;
    bus.rx_axis_fifo_tvalid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      if (bus.rx_axis_fifo_tready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL tready_wait: tready=%b want 1 within 100 cycles",
               bus.rx_axis_fifo_tready);
    end
    #1;
    bus.rx_axis_fifo_tvalid = 1'b0;
    bus.rx_axis_fifo_tlast  = 1'b0;
  endtask

  function automatic logic [7:0] frame_byte(input logic [15:0] et,
                                            input logic [31:0] s, input int i);
    if (i < 6) return 8'hFF;
    if (i < 12) return 8'(8'h10 + i);
    if (i == 12) return et[15:8];
    if (i == 13) return et[7:0];
    if (i < 18) return s[8*(17-i) +: 8];
    return 8'(i);
  endfunction

  task automatic send_frame(input logic [15:0] et, input logic [31:0] s,
                            input int len, input bit en, input bit clr,
                            input int gap);
    bit is_match = (et == ET) && (len >= 18);
    bit is_runt  = (et == ET) && (len >= 14) && (len < 18);
    enable = en;
    for (int i = 0; i < len; i++) begin
      if (i == len - 1) model_acc(is_match, is_runt, s, en, clr);
      send_byte(frame_byte(et, s, i), i == len - 1, gap);
    end
    if (clr) begin
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
    end
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    total++;
    if ({frame_cnt, match_cnt, runt_cnt, lost_cnt, ooo_cnt, last_seq, seq_valid} !== '0) begin
      bad++;
      $display("FAIL clear_zero: got f=%0d m=%0d r=%0d l=%0d o=%0d ls=%h want all 0",
               frame_cnt, match_cnt, runt_cnt, lost_cnt, ooo_cnt, last_seq);
    end
  endtask

  task automatic check_cnts(input string nm, input int f, input int m,
                            input int r, input int l, input int o,
                            input logic [31:0] ls);
    total++;
    if (frame_cnt !== CNT_W'(f) || match_cnt !== CNT_W'(m) ||
        runt_cnt !== CNT_W'(r) || lost_cnt !== CNT_W'(l) ||
        ooo_cnt !== CNT_W'(o) || last_seq !== ls) begin
      bad++;
      $display("FAIL %s: got f=%0d m=%0d r=%0d l=%0d o=%0d ls=%h want f=%0d m=%0d r=%0d l=%0d o=%0d ls=%h",
               nm, frame_cnt, match_cnt, runt_cnt, lost_cnt, ooo_cnt, last_seq,
               f, m, r, l, o, ls);
    end
  endtask

  task automatic test_reset();
    bus.rx_axis_fifo_tvalid = 1'b0;
    bus.rx_axis_fifo_tlast  = 1'b0;
    bus.rx_axis_fifo_tdata  = 8'h00;
    model_clear();
    #3;
    total++;
    if (bus.rx_axis_fifo_tready !== 1'b0) begin
      bad++;
      $display("FAIL reset_tready: got %b want 0", bus.rx_axis_fifo_tready);
    end
    check_cnts("reset_cnts", 0, 0, 0, 0, 0, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.rx_axis_fifo_tready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_tready: got %b want 1", bus.rx_axis_fifo_tready);
    end
  endtask

  task automatic test_in_order();
    do_clear();
    for (int i = 0; i < 3; i++) send_frame(ET, 32'(i), 64, 1'b1, 1'b0, 0);
    drain();
    check_cnts("in_order", 3, 3, 0, 0, 0, 32'd2);
  endtask

  task automatic test_gap_ooo();
    do_clear();
    send_frame(ET, 32'd5, 64, 1'b1, 1'b0, 0);
    send_frame(ET, 32'd9, 64, 1'b1, 1'b0, 0);
    drain();
    check_cnts("gap_lost", 2, 2, 0, 3, 0, 32'd9);
    send_frame(ET, 32'd7, 64, 1'b1, 1'b0, 0);
    drain();
    check_cnts("late_ooo", 3, 3, 0, 3, 1, 32'd7);
    send_frame(ET, 32'd10, 64, 1'b1, 1'b0, 0);
    drain();
    check_cnts("exp_kept", 4, 4, 0, 3, 1, 32'd10);
  endtask

  task automatic test_wrap();
    do_clear();
    send_frame(ET, 32'hFFFF_FFFE, 64, 1'b1, 1'b0, 0);
    send_frame(ET, 32'hFFFF_FFFF, 64, 1'b1, 1'b0, 0);
    send_frame(ET, 32'h0000_0000, 64, 1'b1, 1'b0, 0);
    drain();
    check_cnts("wrap", 3, 3, 0, 0, 0, 32'h0);
  endtask

  task automatic test_runt();
    do_clear();
    send_frame(ET, 32'd1, 16, 1'b1, 1'b0, 0);
    send_frame(16'h0800, 32'd2, 64, 1'b1, 1'b0, 0);
    drain();
    check_cnts("runt_basic", 2, 0, 1, 0, 0, 32'h0);
    send_frame(ET, 32'd3, 14, 1'b1, 1'b0, 0);
    send_frame(ET, 32'd4, 13, 1'b1, 1'b0, 0);
    send_frame(16'h89B5, 32'd5, 64, 1'b1, 1'b0, 0);
    send_frame(16'h88B6, 32'd6, 64, 1'b1, 1'b0, 0);
    send_frame(ET, 32'h1234_5678, 18, 1'b1, 1'b0, 0);
    drain();
    check_cnts("runt_edges", 7, 1, 2, 0, 0, 32'h1234_5678);
  endtask

  task automatic test_enable();
    do_clear();
    send_frame(ET, 32'd0, 40, 1'b1, 1'b0, 0);
    send_frame(ET, 32'd5, 40, 1'b0, 1'b0, 0);
    send_frame(ET, 32'd1, 40, 1'b1, 1'b0, 0);
    drain();
    check_cnts("enable_off", 2, 2, 0, 0, 0, 32'd1);
  endtask

  task automatic test_clear_on_acc();
    do_clear();
    send_frame(ET, 32'd1, 32, 1'b1, 1'b0, 0);
    send_frame(ET, 32'd2, 32, 1'b1, 1'b0, 0);
    send_frame(ET, 32'd3, 32, 1'b1, 1'b1, 0);
    check_cnts("clear_acc", 0, 0, 0, 0, 0, 32'h0);
    send_frame(ET, 32'd10, 32, 1'b1, 1'b0, 0);
    drain();
    check_cnts("first_after_clr", 1, 1, 0, 0, 0, 32'd10);
  endtask

  task automatic test_big_gap();
    do_clear();
    send_frame(ET, 32'd0, 24, 1'b1, 1'b0, 0);
    send_frame(ET, 32'd1000, 24, 1'b1, 1'b0, 0);
    send_frame(ET, 32'd1001, 24, 1'b1, 1'b0, 0);
    drain();
    check_cnts("lost_sat_add", 3, 3, 0, 255, 0, 32'd1001);
  endtask

  task automatic test_midframe_reset();
    enable = 1'b1;
    for (int i = 0; i < 30; i++) send_byte(frame_byte(ET, 32'd77, i), 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    total++;
    if (bus.rx_axis_fifo_tready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_tready: got %b want 0", bus.rx_axis_fifo_tready);
    end
    check_cnts("mid_reset_cnts", 0, 0, 0, 0, 0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(ET, 32'd42, 20, 1'b1, 1'b0, 0);
    drain();
    check_cnts("after_mid_reset", 1, 1, 0, 0, 0, 32'd42);
  endtask

  task automatic test_saturation(input int gap);
    do_clear();
    for (int i = 0; i < 300; i++)
      send_frame(ET, 32'(2 * i), 24, 1'b1, 1'b0, gap);
    drain();
    check_cnts(gap == 0 ? "sat_nogap" : "sat_gaps", 255, 255, 0, 255, 0, 32'd598);
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_gap_ooo();
    test_wrap();
    test_runt();
    test_enable();
    test_clear_on_acc();
    test_big_gap();
    test_midframe_reset();
    test_saturation(0);
    test_saturation(30);
    drain();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d queued want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
